// File: rtl/dma_req_splitter.sv
// ============================================================================
// Module      : dma_req_splitter
// Description : Splits one DMA descriptor into bursts of at most 1 KB that
//               never cross a 1 KB address boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_req_splitter #(
   parameter int ABITS = 48
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_desc_valid,
   output logic             o_desc_ready,
   input  logic             i_desc_write,
   input  logic [ABITS-1:0] i_desc_addr,
   input  logic [15:0]      i_desc_nwords,
   input  logic             i_wdata_valid,
   output logic             o_wdata_ready,
   input  logic [63:0]      i_wdata,
   output logic             o_req_mem_valid,
   input  logic             i_req_mem_ready,
   output logic             o_req_mem_write,
   output logic [9:0]       o_req_mem_bytes,
   output logic [ABITS-1:0] o_req_mem_addr,
   output logic [7:0]       o_req_mem_strob,
   output logic [63:0]      o_req_mem_data,
   output logic             o_req_mem_last,
   input  logic             i_resp_mem_valid,
   output logic             o_resp_mem_ready,
   input  logic             i_resp_mem_last,
   input  logic             i_resp_mem_fault,
   input  logic [63:0]      i_resp_mem_data,
   output logic             o_rdata_valid,
   input  logic             i_rdata_ready,
   output logic [63:0]      o_rdata,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_fault
);

   localparam logic [ABITS-1:0] C_ALIGN_MASK = {{(ABITS-3){1'b1}}, 3'b000};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_REQ  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [ABITS-1:0] addr_q, addr_d;
   logic [15:0]      rem_q, rem_d;
   logic             write_q, write_d;
   logic [6:0]       beat_q, beat_d;
   logic [7:0]       burst_q, burst_d;
   logic [9:0]       bytes_q, bytes_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;

   logic [7:0]       w_to_bnd;
   logic [7:0]       w_burst;
   logic             w_in_req;
   logic             w_in_resp;
   logic             w_beat_hs;
   logic             w_resp_hs;
   logic [15:0]      w_rem_next;
   logic [ABITS-1:0] w_addr_next;

   // Words left before the next 1 KB boundary; 128 when already aligned.
   assign w_to_bnd    = 8'd128 - {1'b0, addr_q[9:3]};
   assign w_burst     = (rem_q < {8'd0, w_to_bnd}) ? rem_q[7:0] : w_to_bnd;
   assign w_rem_next  = rem_q - {8'd0, burst_q};
   assign w_addr_next = addr_q + {{(ABITS-11){1'b0}}, burst_q, 3'b000};

   assign w_in_req    = (state_q == ST_REQ);
   assign w_in_resp   = (state_q == ST_RESP);
   assign w_beat_hs   = i_wdata_valid & i_req_mem_ready;
   assign w_resp_hs   = i_resp_mem_valid & o_resp_mem_ready;

   assign o_desc_ready     = (state_q == ST_IDLE);
   assign o_busy           = (state_q != ST_IDLE);
   assign o_done           = done_q;
   assign o_fault          = fault_q;

   assign o_req_mem_valid  = w_in_req & (write_q ? i_wdata_valid : 1'b1);
   assign o_wdata_ready    = w_in_req & write_q & i_req_mem_ready;
   assign o_req_mem_write  = write_q;
   assign o_req_mem_bytes  = bytes_q;
   assign o_req_mem_addr   = addr_q;
   assign o_req_mem_strob  = {8{write_q}};
   assign o_req_mem_data   = (w_in_req & write_q) ? i_wdata : 64'd0;
   assign o_req_mem_last   = write_q ? (beat_q == 7'd0) : 1'b1;

   assign o_resp_mem_ready = w_in_resp & (write_q | i_rdata_ready);
   assign o_rdata_valid    = w_in_resp & ~write_q & i_resp_mem_valid;
   assign o_rdata          = (w_in_resp & ~write_q) ? i_resp_mem_data : 64'd0;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      write_d = write_q;
      beat_d  = beat_q;
      burst_d = burst_q;
      bytes_d = bytes_q;
      done_d  = 1'b0;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (i_desc_valid) begin
               addr_d  = i_desc_addr & C_ALIGN_MASK;
               rem_d   = i_desc_nwords;
               write_d = i_desc_write;
               fault_d = 1'b0;
               if (i_desc_nwords == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            // A full 128-word burst encodes as 0 bytes and 127 remaining beats.
            burst_d = w_burst;
            bytes_d = {w_burst[6:0], 3'b000};
            beat_d  = w_burst[6:0] - 7'd1;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (write_q) begin
               if (w_beat_hs) begin
                  beat_d = beat_q - 7'd1;
                  if (beat_q == 7'd0) begin
                     state_d = ST_RESP;
                  end
               end
            end else if (i_req_mem_ready) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (w_resp_hs) begin
               if (i_resp_mem_fault) begin
                  fault_d = 1'b1;
               end
               if (i_resp_mem_last) begin
                  addr_d = w_addr_next;
                  rem_d  = w_rem_next;
                  if (w_rem_next == 16'd0) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_CALC;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         write_q <= 1'b0;
         beat_q  <= '0;
         burst_q <= '0;
         bytes_q <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         write_q <= write_d;
         beat_q  <= beat_d;
         burst_q <= burst_d;
         bytes_q <= bytes_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_req_splitter.sv
// ============================================================================
// Module      : tb_dma_req_splitter
// Description : Self-checking bench for dma_req_splitter (descriptor table
//               plus scoreboard of requests, read data and completions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_req_splitter;

   localparam int ABITS = 48;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_desc_valid, o_desc_ready, i_desc_write;
   logic [ABITS-1:0] i_desc_addr;
   logic [15:0]      i_desc_nwords;
   logic             i_wdata_valid, o_wdata_ready;
   logic [63:0]      i_wdata;
   logic             o_req_mem_valid, i_req_mem_ready, o_req_mem_write;
   logic [9:0]       o_req_mem_bytes;
   logic [ABITS-1:0] o_req_mem_addr;
   logic [7:0]       o_req_mem_strob;
   logic [63:0]      o_req_mem_data;
   logic             o_req_mem_last;
   logic             i_resp_mem_valid, o_resp_mem_ready, i_resp_mem_last, i_resp_mem_fault;
   logic [63:0]      i_resp_mem_data;
   logic             o_rdata_valid, i_rdata_ready;
   logic [63:0]      o_rdata;
   logic             o_busy, o_done, o_fault;

   dma_req_splitter #(.ABITS(ABITS)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
      .i_desc_write(i_desc_write), .i_desc_addr(i_desc_addr), .i_desc_nwords(i_desc_nwords),
      .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
      .o_req_mem_valid(o_req_mem_valid), .i_req_mem_ready(i_req_mem_ready),
      .o_req_mem_write(o_req_mem_write), .o_req_mem_bytes(o_req_mem_bytes),
      .o_req_mem_addr(o_req_mem_addr), .o_req_mem_strob(o_req_mem_strob),
      .o_req_mem_data(o_req_mem_data), .o_req_mem_last(o_req_mem_last),
      .i_resp_mem_valid(i_resp_mem_valid), .o_resp_mem_ready(o_resp_mem_ready),
      .i_resp_mem_last(i_resp_mem_last), .i_resp_mem_fault(i_resp_mem_fault),
      .i_resp_mem_data(i_resp_mem_data),
      .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
      .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic             wr;
      logic [ABITS-1:0] addr;
      logic [9:0]       bytes;
      logic [7:0]       strob;
      logic [63:0]      data;
      logic             last;
   } req_t;

   typedef struct {
      logic                  wr;
      logic [ABITS-1:0]      addr;
      logic [15:0]           nw;
      int                    nb;
      logic [2:0][ABITS-1:0] ba;
      logic [2:0][9:0]       bb;
      logic                  flt;
   } vec_t;

   req_t        req_q[$];
   logic [63:0] rd_q[$];
   logic        done_q[$];
   int          checks   = 0;
   int          failures = 0;
   vec_t        vecs[11];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   function automatic vec_t mk(input logic wr, input logic [ABITS-1:0] a, input logic [15:0] nw,
                               input int nb, input logic [ABITS-1:0] a0, input logic [9:0] b0,
                               input logic [ABITS-1:0] a1, input logic [9:0] b1,
                               input logic [ABITS-1:0] a2, input logic [9:0] b2, input logic flt);
      vec_t v;
      v.wr = wr; v.addr = a; v.nw = nw; v.nb = nb; v.flt = flt;
      v.ba[0] = a0; v.ba[1] = a1; v.ba[2] = a2;
      v.bb[0] = b0; v.bb[1] = b1; v.bb[2] = b2;
      return v;
   endfunction

   function automatic int words_of(input logic [9:0] b);
      return (b == 10'd0) ? 128 : int'(b) / 8;
   endfunction

   // Scoreboard: compares every handshake the DUT produces.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_req_mem_valid && i_req_mem_ready) begin
            if (req_q.size() == 0) fail_to("req_unexpected");
            else begin
               req_t e;
               e = req_q.pop_front();
               chk("req_beat",
                   {o_req_mem_write, o_req_mem_addr, o_req_mem_bytes, o_req_mem_strob, o_req_mem_data, o_req_mem_last},
                   {e.wr, e.addr, e.bytes, e.strob, e.data, e.last});
            end
         end
         if (o_rdata_valid && i_rdata_ready) begin
            if (rd_q.size() == 0) fail_to("rdata_unexpected");
            else chk("rdata", o_rdata, rd_q.pop_front());
         end
         if (o_done) begin
            if (done_q.size() == 0) fail_to("done_unexpected");
            else chk("done_state", {o_fault, o_busy}, {done_q.pop_front(), 1'b0});
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      chk(name, {o_desc_ready, o_busy, o_done, o_fault, o_req_mem_valid, o_wdata_ready,
                 o_rdata_valid, o_resp_mem_ready}, 8'b1000_0000);
      chk({name, "_data"}, {o_req_mem_addr, o_req_mem_bytes, o_req_mem_data, o_rdata}, 256'd0);
   endtask

   task automatic accept(input logic wr, input logic [ABITS-1:0] a, input logic [15:0] nw);
      i_desc_valid = 1'b1; i_desc_write = wr; i_desc_addr = a; i_desc_nwords = nw;
      @(negedge i_clk);
      chk("desc_ready", o_desc_ready, 1'b1);
      tick();
      i_desc_valid = 1'b0;
      chk("fault_cleared", o_fault, 1'b0);
      chk("busy_after_accept", o_busy, nw != 16'd0);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_req_mem_valid && n < 50);
      if (!o_req_mem_valid) fail_to("req_wait");
   endtask

   task automatic read_burst(input int words, input logic flt);
      int n;
      logic [63:0] d;
      wait_req(n);
      chk("req_latency", n, 2);
      tick();
      for (int k = 0; k < words; k++) begin
         d = {$urandom, $urandom};
         i_resp_mem_valid = 1'b1; i_resp_mem_data = d; i_resp_mem_last = (k == words - 1);
         i_resp_mem_fault = flt && (k == 0);
         if (k % 5 == 3) begin
            i_rdata_ready = 1'b0;
            @(negedge i_clk);
            chk("rdata_stall_ready", o_resp_mem_ready, 1'b0);
            tick();
            i_rdata_ready = 1'b1;
         end
         rd_q.push_back(d);
         tick();
      end
      i_resp_mem_valid = 1'b0; i_resp_mem_last = 1'b0; i_resp_mem_fault = 1'b0;
   endtask

   task automatic drive_wbeat(input logic [63:0] d);
      int n;
      i_wdata_valid = 1'b1; i_wdata = d; n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!(o_req_mem_valid && o_wdata_ready) && n < 50);
      if (!(o_req_mem_valid && o_wdata_ready)) fail_to("wbeat_wait");
      tick();
      i_wdata_valid = 1'b0; i_wdata = 64'd0;
   endtask

   task automatic write_resp(input logic flt);
      int n;
      i_resp_mem_valid = 1'b1; i_resp_mem_last = 1'b1; i_resp_mem_fault = flt; n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_resp_mem_ready && n < 20);
      if (!o_resp_mem_ready) fail_to("wresp_wait");
      tick();
      i_resp_mem_valid = 1'b0; i_resp_mem_last = 1'b0; i_resp_mem_fault = 1'b0;
   endtask

   task automatic finish_desc();
      @(negedge i_clk);
      chk("done_pulse", o_done, 1'b1);
      tick();
      @(negedge i_clk);
      chk("done_single", o_done, 1'b0);
      tick();
   endtask

   task automatic run_desc(input vec_t v);
      logic [63:0] wq[$];
      logic [63:0] d;
      int words;
      for (int b = 0; b < v.nb; b++) begin
         words = words_of(v.bb[b]);
         if (v.wr) begin
            for (int k = 0; k < words; k++) begin
               d = {$urandom, $urandom};
               wq.push_back(d);
               req_q.push_back('{1'b1, v.ba[b], v.bb[b], 8'hFF, d, (k == words - 1)});
            end
         end else begin
            req_q.push_back('{1'b0, v.ba[b], v.bb[b], 8'h00, 64'd0, 1'b1});
         end
      end
      done_q.push_back(v.flt);
      accept(v.wr, v.addr, v.nw);
      for (int b = 0; b < v.nb; b++) begin
         words = words_of(v.bb[b]);
         if (v.wr) begin
            for (int k = 0; k < words; k++) drive_wbeat(wq.pop_front());
            write_resp(v.flt && b == 0);
         end else begin
            read_burst(words, v.flt && b == 0);
         end
      end
      if (v.nb == 0) begin
         @(negedge i_clk);
         chk("empty_no_req", o_req_mem_valid, 1'b0);
         chk("empty_done", o_done, 1'b1);
         tick();
      end else begin
         finish_desc();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      logic [63:0] d;

      vecs[0]  = mk(0, 48'h100, 4, 1, 48'h100, 10'd32, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 48'h3F0, 200, 3, 48'h3F0, 10'd16, 48'h400, 10'd0, 48'h800, 10'd560, 0);
      vecs[2]  = mk(0, 48'h3F8, 1, 1, 48'h3F8, 10'd8, 0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 48'h0, 128, 1, 48'h0, 10'd0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 48'h7, 129, 2, 48'h0, 10'd0, 48'h400, 10'd8, 0, 0, 0);
      vecs[5]  = mk(0, 48'hFFFF_FFFF_FF00, 64, 2, 48'hFFFF_FFFF_FF00, 10'd256, 48'h0, 10'd256, 0, 0, 0);
      vecs[6]  = mk(1, 48'h8, 3, 1, 48'h8, 10'd24, 0, 0, 0, 0, 0);
      vecs[7]  = mk(1, 48'h3E0, 6, 2, 48'h3E0, 10'd32, 48'h400, 10'd16, 0, 0, 1);
      vecs[8]  = mk(0, 48'h3F8, 3, 2, 48'h3F8, 10'd8, 48'h400, 10'd16, 0, 0, 1);
      vecs[9]  = mk(0, 48'h40, 2, 1, 48'h40, 10'd16, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 48'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      i_rst = 1'b1;
      i_desc_valid = 0; i_desc_write = 0; i_desc_addr = '0; i_desc_nwords = '0;
      i_wdata_valid = 0; i_wdata = '0; i_req_mem_ready = 1'b1;
      i_resp_mem_valid = 0; i_resp_mem_last = 0; i_resp_mem_fault = 0; i_resp_mem_data = '0;
      i_rdata_ready = 1'b1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check_reset_outputs("reset_init");
      tick();
      i_rst = 1'b0;

      i_resp_mem_valid = 1'b1; i_resp_mem_last = 1'b1; i_resp_mem_data = 64'hDEAD;
      @(negedge i_clk);
      chk("idle_resp_ignored", {o_resp_mem_ready, o_rdata_valid}, 2'b00);
      tick();
      i_resp_mem_valid = 1'b0; i_resp_mem_last = 1'b0; i_resp_mem_data = '0;

      for (int i = 0; i < 11; i++) run_desc(vecs[i]);

      // Write burst with a two-cycle data gap and one cycle of request backpressure.
      req_q.push_back('{1'b1, 48'h8, 10'd24, 8'hFF, 64'hA, 1'b0});
      req_q.push_back('{1'b1, 48'h8, 10'd24, 8'hFF, 64'hB, 1'b0});
      req_q.push_back('{1'b1, 48'h8, 10'd24, 8'hFF, 64'hC, 1'b1});
      done_q.push_back(1'b0);
      accept(1'b1, 48'h8, 16'd3);
      drive_wbeat(64'hA);
      repeat (2) begin
         @(negedge i_clk);
         chk("gap_no_valid", o_req_mem_valid, 1'b0);
         tick();
      end
      i_req_mem_ready = 1'b0; i_wdata_valid = 1'b1; i_wdata = 64'hB;
      @(negedge i_clk);
      chk("stall_wdata_ready", o_wdata_ready, 1'b0);
      tick();
      i_req_mem_ready = 1'b1;
      drive_wbeat(64'hB);
      drive_wbeat(64'hC);
      write_resp(1'b0);
      finish_desc();

      // Asynchronous reset in the middle of a read response.
      req_q.push_back('{1'b0, 48'h100, 10'd32, 8'h00, 64'd0, 1'b1});
      accept(1'b0, 48'h100, 16'd4);
      wait_req(n);
      tick();
      d = {$urandom, $urandom};
      rd_q.push_back(d);
      i_resp_mem_valid = 1'b1; i_resp_mem_data = d; i_resp_mem_last = 1'b0;
      tick();
      i_resp_mem_data = d ^ 64'h1;
      #2;
      i_rst = 1'b1;
      #1;
      check_reset_outputs("reset_async");
      i_resp_mem_valid = 1'b0; i_resp_mem_data = '0;
      tick();
      tick();
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("no_done_after_reset", o_done, 1'b0);
      tick();
      run_desc(vecs[0]);

      chk("req_q_empty", req_q.size(), 0);
      chk("rd_q_empty", rd_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
